// File: rtl/maint_scheduler.sv
// ---------------------------------------------------------------------------
// maint_scheduler
//
// Generates periodic maintenance requests (auto-refresh, ZQ-short and a
// periodic dummy read) for maint_handler. Each source has its own interval
// timer. Refresh ticks accumulate as postponed-refresh credits. ZQ and
// periodic-read ticks set a single pending flag, so repeated ticks merge.
// Each source runs a req/ack handshake toward maint_handler.
//
// Ports:
//   clk, rst         fabric clock, synchronous active-high reset
//   aref_en          enable auto-refresh timer
//   aref_interval    refresh period in clk cycles (tREFI)
//   zq_en            enable ZQ-short timer
//   zq_interval      ZQCS period in clk cycles
//   pr_rd_en         enable periodic-read timer
//   pr_rd_interval   periodic-read period in clk cycles
//   autoref_req      refresh requested (credits > 0)
//   autoref_ack      one-cycle pulse, one refresh completed
//   zq_req           ZQ-short requested
//   zq_ack           one-cycle pulse, ZQ-short completed
//   pr_rd_req        periodic dummy read requested
//   pr_rd_ack        one-cycle pulse, periodic read consumed
//   ref_pending      current refresh credit count
//   ref_urgent       ref_pending >= URGENT_PEND
//   ref_overflow     sticky, a refresh tick was lost at MAX_PEND
// ---------------------------------------------------------------------------
module maint_scheduler #(
  parameter int MAX_PEND    = 8,
  parameter int URGENT_PEND = 6,
  parameter int CNT_W       = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aref_en,
  input  logic [CNT_W-1:0] aref_interval,
  input  logic             zq_en,
  input  logic [CNT_W-1:0] zq_interval,
  input  logic             pr_rd_en,
  input  logic [CNT_W-1:0] pr_rd_interval,
  output logic             autoref_req,
  input  logic             autoref_ack,
  output logic             zq_req,
  input  logic             zq_ack,
  output logic             pr_rd_req,
  input  logic             pr_rd_ack,
  output logic [3:0]       ref_pending,
  output logic             ref_urgent,
  output logic             ref_overflow
);

  localparam logic [3:0] MaxPend    = 4'(MAX_PEND);
  localparam logic [3:0] UrgentPend = 4'(URGENT_PEND);

  logic [CNT_W-1:0] arefTimer_q, arefTimer_d;
  logic [CNT_W-1:0] zqTimer_q, zqTimer_d;
  logic [CNT_W-1:0] prTimer_q, prTimer_d;
  logic [3:0]       credits_q, credits_d;
  logic             overflow_q, overflow_d;
  logic             zqFlag_q, zqFlag_d;
  logic             prFlag_q, prFlag_d;

  logic             arefTick;
  logic             zqTick;
  logic             prTick;

  // Tick threshold is max(interval,1)-1, so intervals 0 and 1 both tick
  // every cycle. The >= compare makes a lowered interval take effect at once.
  function automatic logic [CNT_W-1:0] tickThresh(input logic [CNT_W-1:0] iv);
    logic [CNT_W-1:0] thr;
    thr = '0;
    if (iv != '0) begin
      thr = iv - 1'b1;
    end
    return thr;
  endfunction

  // Timers count while enabled and wrap to 0 on the cycle they tick.
  // A disabled timer is held at 0 so the first tick after enabling lands
  // exactly one full interval later.
  always_comb begin
    arefTick    = aref_en  && (arefTimer_q >= tickThresh(aref_interval));
    zqTick      = zq_en    && (zqTimer_q   >= tickThresh(zq_interval));
    prTick      = pr_rd_en && (prTimer_q   >= tickThresh(pr_rd_interval));

    arefTimer_d = '0;
    zqTimer_d   = '0;
    prTimer_d   = '0;
    if (aref_en && !arefTick) begin
      arefTimer_d = arefTimer_q + 1'b1;
    end
    if (zq_en && !zqTick) begin
      zqTimer_d = zqTimer_q + 1'b1;
    end
    if (pr_rd_en && !prTick) begin
      prTimer_d = prTimer_q + 1'b1;
    end
  end

  // Refresh credits: a tick and an ack in the same cycle cancel out.
  // A tick at the credit ceiling is dropped and recorded in the sticky
  // overflow flag. An ack with no credits outstanding is ignored.
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (arefTick && !autoref_ack) begin
      if (credits_q < MaxPend) begin
        credits_d = credits_q + 4'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (!arefTick && autoref_ack && (credits_q != 4'd0)) begin
      credits_d = credits_q - 4'd1;
    end
  end

  // ZQ and periodic-read flags: a coincident tick wins over the ack, so a
  // request that arrives as the previous one is consumed is not lost. The
  // periodic-read flag must remain set until acked because the handler's
  // read lock is released only by that ack.
  always_comb begin
    zqFlag_d = zqFlag_q;
    prFlag_d = prFlag_q;
    if (zqTick) begin
      zqFlag_d = 1'b1;
    end else if (zq_ack) begin
      zqFlag_d = 1'b0;
    end
    if (prTick) begin
      prFlag_d = 1'b1;
    end else if (pr_rd_ack) begin
      prFlag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arefTimer_q <= '0;
      zqTimer_q   <= '0;
      prTimer_q   <= '0;
      credits_q   <= 4'd0;
      overflow_q  <= 1'b0;
      zqFlag_q    <= 1'b0;
      prFlag_q    <= 1'b0;
    end else begin
      arefTimer_q <= arefTimer_d;
      zqTimer_q   <= zqTimer_d;
      prTimer_q   <= prTimer_d;
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
      zqFlag_q    <= zqFlag_d;
      prFlag_q    <= prFlag_d;
    end
  end

  // Requests are independent; arbitration between sources is the handler's job.
  assign autoref_req  = (credits_q != 4'd0);
  assign ref_pending  = credits_q;
  assign ref_urgent   = (credits_q >= UrgentPend);
  assign ref_overflow = overflow_q;
  assign zq_req       = zqFlag_q;
  assign pr_rd_req    = prFlag_q;

endmodule

// File: tb/tb_maint_scheduler.sv
// ---------------------------------------------------------------------------
// tb_maint_scheduler
//
// Drives maint_scheduler with directed scenarios followed by randomized
// traffic. A behavioural model tracks the elapsed cycles per source, the
// number of postponed refreshes and the pending ZQ/read requests. Every
// DUT output is compared with this model after each clock.
// ---------------------------------------------------------------------------
module tb_maint_scheduler;

  localparam int MaxPend    = 8;
  localparam int UrgentPend = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        aref_en, zq_en, pr_rd_en;
  logic [27:0] aref_interval, zq_interval, pr_rd_interval;
  logic        autoref_ack, zq_ack, pr_rd_ack;
  logic        autoref_req, zq_req, pr_rd_req;
  logic [3:0]  ref_pending;
  logic        ref_urgent, ref_overflow;

  int numChecks = 0;
  int numErrors = 0;

  // Reference model state
  longint elapsedAref, elapsedZq, elapsedPr;
  int     mCredits;
  bit     mOverflow, mZq, mPr;

  maint_scheduler #(.MAX_PEND(MaxPend), .URGENT_PEND(UrgentPend), .CNT_W(28)) dut (
    .clk            (clk),
    .rst            (rst),
    .aref_en        (aref_en),
    .aref_interval  (aref_interval),
    .zq_en          (zq_en),
    .zq_interval    (zq_interval),
    .pr_rd_en       (pr_rd_en),
    .pr_rd_interval (pr_rd_interval),
    .autoref_req    (autoref_req),
    .autoref_ack    (autoref_ack),
    .zq_req         (zq_req),
    .zq_ack         (zq_ack),
    .pr_rd_req      (pr_rd_req),
    .pr_rd_ack      (pr_rd_ack),
    .ref_pending    (ref_pending),
    .ref_urgent     (ref_urgent),
    .ref_overflow   (ref_overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    numChecks++;
    if (observed != expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // A source fires once a full period (at least one cycle) has elapsed
  function automatic bit periodDone(input bit en, input longint iv, input longint elapsed);
    longint period;
    period = (iv < 1) ? 1 : iv;
    return en && (elapsed + 1 >= period);
  endfunction

  // Advance one clock with the inputs currently driven, update the model
  // from the rules, then compare every output.
  task automatic applyStimulus();
    bit ta, tz, tp;
    ta = periodDone(aref_en, longint'(aref_interval), elapsedAref);
    tz = periodDone(zq_en, longint'(zq_interval), elapsedZq);
    tp = periodDone(pr_rd_en, longint'(pr_rd_interval), elapsedPr);
    @(posedge clk);
    #1;
    if (rst) begin
      elapsedAref = 0; elapsedZq = 0; elapsedPr = 0;
      mCredits = 0; mOverflow = 0; mZq = 0; mPr = 0;
    end else begin
      elapsedAref = (!aref_en || ta) ? 0 : elapsedAref + 1;
      elapsedZq   = (!zq_en   || tz) ? 0 : elapsedZq + 1;
      elapsedPr   = (!pr_rd_en || tp) ? 0 : elapsedPr + 1;
      if (ta && !autoref_ack) begin
        if (mCredits == MaxPend) mOverflow = 1;
        else mCredits++;
      end else if (!ta && autoref_ack && mCredits > 0) begin
        mCredits--;
      end
      mZq = tz ? 1'b1 : (zq_ack ? 1'b0 : mZq);
      mPr = tp ? 1'b1 : (pr_rd_ack ? 1'b0 : mPr);
    end
    checkOutput("autoref_req", autoref_req, mCredits > 0);
    checkOutput("ref_pending", ref_pending, mCredits);
    checkOutput("ref_urgent", ref_urgent, mCredits >= UrgentPend);
    checkOutput("ref_overflow", ref_overflow, mOverflow);
    checkOutput("zq_req", zq_req, mZq);
    checkOutput("pr_rd_req", pr_rd_req, mPr);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    aref_en = 0; zq_en = 0; pr_rd_en = 0;
    aref_interval = 0; zq_interval = 0; pr_rd_interval = 0;
    autoref_ack = 0; zq_ack = 0; pr_rd_ack = 0;
    elapsedAref = 0; elapsedZq = 0; elapsedPr = 0;
    mCredits = 0; mOverflow = 0; mZq = 0; mPr = 0;

    // Reset state
    applyStimulus();
    checkOutput("reset_pending", ref_pending, 0);
    checkOutput("reset_zq", zq_req, 0);
    rst = 1'b0;
    applyStimulus();

    // T1: first refresh after exactly 100 cycles, second 100 later
    $display("[TB] T1 refresh interval 100");
    aref_interval = 28'd100;
    aref_en = 1'b1;
    runCycles(99);
    checkOutput("t1_no_req_yet", autoref_req, 0);
    applyStimulus();
    checkOutput("t1_first_req", autoref_req, 1);
    checkOutput("t1_pending1", ref_pending, 1);
    runCycles(100);
    checkOutput("t1_pending2", ref_pending, 2);

    // T2: fill credits to the ceiling, one extra tick overflows
    $display("[TB] T2 credit ceiling");
    aref_interval = 28'd10;
    for (int i = 0; i < 200 && mCredits < MaxPend; i++) applyStimulus();
    checkOutput("t2_full", ref_pending, MaxPend);
    checkOutput("t2_no_ovf_yet", ref_overflow, 0);
    runCycles(10);
    checkOutput("t2_held", ref_pending, MaxPend);
    checkOutput("t2_overflow", ref_overflow, 1);
    aref_en = 1'b0;
    pulseReset();
    checkOutput("t2_rst_pending", ref_pending, 0);
    checkOutput("t2_rst_ovf", ref_overflow, 0);

    // T3: coincident tick and ack, ack-only, ack at zero
    $display("[TB] T3 tick/ack interaction");
    aref_en = 1'b1;
    for (int i = 0; i < 100 && mCredits < 3; i++) applyStimulus();
    for (int i = 0; i < 20; i++) begin
      if (periodDone(aref_en, longint'(aref_interval), elapsedAref)) break;
      applyStimulus();
    end
    autoref_ack = 1'b1;
    applyStimulus();
    autoref_ack = 1'b0;
    checkOutput("t3_tick_ack", ref_pending, 3);
    aref_en = 1'b0;
    autoref_ack = 1'b1;
    applyStimulus();
    checkOutput("t3_ack_only", ref_pending, 2);
    runCycles(2);
    checkOutput("t3_drained", ref_pending, 0);
    applyStimulus();
    checkOutput("t3_ack_at_zero", ref_pending, 0);
    autoref_ack = 1'b0;

    // T4: ZQ request merges ticks and re-arms after ack
    $display("[TB] T4 ZQ interval 50");
    zq_interval = 28'd50;
    zq_en = 1'b1;
    runCycles(49);
    checkOutput("t4_before", zq_req, 0);
    applyStimulus();
    checkOutput("t4_rise", zq_req, 1);
    runCycles(120);
    checkOutput("t4_held", zq_req, 1);
    zq_ack = 1'b1;
    applyStimulus();
    zq_ack = 1'b0;
    checkOutput("t4_acked", zq_req, 0);
    for (int i = 0; i < 60 && !mZq; i++) applyStimulus();
    checkOutput("t4_rerise", zq_req, 1);
    zq_en = 1'b0;

    // T5: periodic read every cycle, ack loses to the coincident tick
    $display("[TB] T5 periodic read interval 1");
    pr_rd_interval = 28'd1;
    pr_rd_en = 1'b1;
    applyStimulus();
    checkOutput("t5_rise", pr_rd_req, 1);
    pr_rd_ack = 1'b1;
    applyStimulus();
    pr_rd_ack = 1'b0;
    checkOutput("t5_tick_wins", pr_rd_req, 1);
    pr_rd_en = 1'b0;
    applyStimulus();
    checkOutput("t5_held_disabled", pr_rd_req, 1);
    pr_rd_ack = 1'b1;
    applyStimulus();
    pr_rd_ack = 1'b0;
    checkOutput("t5_cleared", pr_rd_req, 0);
    runCycles(5);
    checkOutput("t5_stays_low", pr_rd_req, 0);

    // T6: reset mid-operation, then urgent threshold
    $display("[TB] T6 reset during activity and urgency");
    pulseReset();
    aref_interval = 28'd4;
    zq_interval = 28'd7;
    aref_en = 1'b1;
    zq_en = 1'b1;
    for (int i = 0; i < 100 && !(mCredits == 5 && mZq); i++) applyStimulus();
    checkOutput("t6_pre_pending", ref_pending, 5);
    checkOutput("t6_pre_zq", zq_req, 1);
    aref_en = 1'b0;
    zq_en = 1'b0;
    pulseReset();
    checkOutput("t6_rst_pending", ref_pending, 0);
    checkOutput("t6_rst_zq", zq_req, 0);
    checkOutput("t6_rst_aref", autoref_req, 0);
    aref_en = 1'b1;
    for (int i = 0; i < 100 && mCredits < UrgentPend; i++) applyStimulus();
    aref_en = 1'b0;
    checkOutput("t6_urgent", ref_urgent, 1);
    autoref_ack = 1'b1;
    applyStimulus();
    autoref_ack = 1'b0;
    checkOutput("t6_not_urgent", ref_urgent, 0);
    checkOutput("t6_pending5", ref_pending, 5);

    // Randomized traffic
    $display("[TB] random phase");
    pulseReset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) aref_en = ~aref_en;
      if ($urandom_range(0, 39) == 0) zq_en = ~zq_en;
      if ($urandom_range(0, 39) == 0) pr_rd_en = ~pr_rd_en;
      if ($urandom_range(0, 79) == 0) aref_interval = 28'($urandom_range(0, 12));
      if ($urandom_range(0, 79) == 0) zq_interval = 28'($urandom_range(0, 30));
      if ($urandom_range(0, 79) == 0) pr_rd_interval = 28'($urandom_range(0, 30));
      autoref_ack = ($urandom_range(0, 9) == 0);
      zq_ack = ($urandom_range(0, 7) == 0);
      pr_rd_ack = ($urandom_range(0, 7) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
